max7219_receiver: RTL
=====================

# max7219_receiver

Clocked SPI receiver that models the MAX7219 display-driver end of the serial link driven by our matrix driver and SPI master. It samples DIN/CS/SCLK in its own clock domain, assembles 16-bit frames and decodes them into the MAX7219 register set: 8 digit rows, decode mode, intensity, scan limit, shutdown and display test. It serves as the on-chip loopback checker and the self-checking bench model for every block that talks to the LED matrix.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `cs_in`, `sclk_in` and `din_in`; minimum 2.
- `clk`  input  1  system clock (1 MHz in silicon; must be at least 2·(SYNC_STAGES+1) times the SCLK frequency).
- `rst`  input  1  asynchronous reset, active-high. One clock; reset is asynchronous and active-high.
- `cs_in`  input  1  chip select, active-low, asynchronous to `clk`.
- `sclk_in`  input  1  serial clock, data sampled on rising edge, asynchronous.
- `din_in`  input  1  serial data, MSB first, asynchronous.
- `row_sel`  input  3  digit row read address (0 = digit 0).
- `row_data`  output  8  stored row selected by `row_sel`, combinational from the register file.
- `decode_mode`  output  8  register 0x9.
- `intensity`  output  4  register 0xA, bits [3:0].
- `scan_limit`  output  3  register 0xB, bits [2:0].
- `shutdown`  output  1  1 = shut down; cleared by register 0xC bit 0 = 1.
- `display_test`  output  1  register 0xF bit 0.
- `frame_valid`  output  1  one-cycle pulse per accepted frame.
- `frame_addr`  output  4  address of last accepted frame.
- `frame_data`  output  8  data of last accepted frame.
- `frame_error`  output  1  one-cycle pulse when CS rises after fewer than 16 bits.
- `dout_out`  output  1  daisy-chain output: shift-register bit 15, updated on SCLK falling edge.

## Operation
- Each input passes through SYNC_STAGES flops, then a one-flop edge detector yielding `cs_fall`, `cs_rise`, `sclk_rise`, `sclk_fall`.
- States: IDLE (waiting for CS low), SHIFT (CS low), DISARMED (after reset with CS sampled low; waits for CS high before returning to IDLE).
- IDLE: `cs_fall` → SHIFT, bit counter := 0. Shift register is not cleared.
- SHIFT: `sclk_rise` → shift := {shift[14:0], din_sync}; bit counter increments, saturating at 16 (5-bit counter). `sclk_fall` → `dout_out` := shift[15].
- SHIFT and `cs_rise`: counter ≥ 16 → latch last 16 bits shifted in; addr = bits[11:8], data = bits[7:0]; bits[15:12] ignored; pulse `frame_valid`, update `frame_addr`/`frame_data`. Counter < 16 → pulse `frame_error`, no register change. Either way → IDLE.
- Decode: 0x0 no-op; 0x1–0x8 row[addr-1] := data; 0x9 decode_mode; 0xA intensity := data[3:0]; 0xB scan_limit := data[2:0]; 0xC shutdown := ~data[0]; 0xF display_test := data[0]; 0xD, 0xE ignored. All addresses, including no-op/ignored, still pulse `frame_valid`.
- `shutdown` and `display_test` do not alter stored rows; `row_data` always returns raw stored content.
- SCLK edges while CS high are ignored; `dout_out` holds.
- Same-cycle `cs_rise` and `sclk_rise`: `cs_rise` wins, the SCLK edge is dropped.
- `cs_fall` with SCLK high: no shift; the first counted bit is the next `sclk_rise`.

## Timing
- Reset values: rows 0x00, decode_mode 0x00, intensity 0, scan_limit 0, shutdown 1, display_test 0, frame_addr 0, frame_data 0, frame_valid 0, frame_error 0, dout_out 0, counter 0, synchronizers 0.
- Reset release: state = IDLE if the synchronized CS is high, otherwise DISARMED. A frame interrupted by reset is discarded without `frame_error`.
- Latency: a pin edge is detected on the (SYNC_STAGES+1)-th `clk` rising edge after it becomes stable. Register updates and `frame_valid` land on that same edge for `cs_rise`.
- `frame_valid` and `frame_error` are high for exactly one `clk` cycle and are never high together.
- SCLK high and low phases, and CS setup/hold to SCLK, must each be ≥ SYNC_STAGES+1 `clk` cycles. Faster input is out of spec and is not detected.

## Structure
- Package `max7219_pkg`: register address constants (NOOP, DIGIT0–7, DECODE, INTENSITY, SCANLIMIT, SHUTDOWN, TEST), reset values, frame width 16, and the state encoding.
- Sub-module `spi_sync_edge`: SYNC_STAGES synchronizer plus rise/fall detect, instantiated three times.

## Test plan
- Reset, then frame 0x0C01 → `shutdown` 0, `frame_valid` one cycle, `frame_addr` 0xC, `frame_data` 0x01.
- Frames 0x0355 and 0x08AA → `row_sel`=2 reads 0x55, `row_sel`=7 reads 0xAA, other rows 0x00.
- 15-bit frame 0x0A0F → `frame_error` pulse, `intensity` stays 0.
- 24-bit frame 0xFF0A07 → `intensity` 7 (last 16 bits); `dout_out` then replays the earlier bits in the same order.
- `rst` pulsed after 8 bits of 0x0B07 with CS held low, then CS rises → no `frame_valid`, no `frame_error`; the next full frame 0x0B07 → `scan_limit` 7.
- Frames 0x0D55 and 0x0000 → `frame_valid` each, all registers unchanged; 0x0F01 then 0x0F00 → `display_test` 1 then 0, rows unchanged.

Source files
------------

// File: rtl/max7219_pkg.sv
// max7219_pkg
//   Shared definitions for the MAX7219 receiver model: register address map,
//   power-on register values, frame geometry and the receiver state encoding.
package max7219_pkg;

  localparam int FRAME_BITS = 16;
  localparam int NUM_ROWS   = 8;

  // Register address map (frame bits [11:8])
  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  // Power-on register contents
  localparam logic [7:0] RST_ROW       = 8'h00;
  localparam logic [7:0] RST_DECODE    = 8'h00;
  localparam logic [3:0] RST_INTENSITY = 4'h0;
  localparam logic [2:0] RST_SCANLIMIT = 3'h0;
  localparam logic       RST_SHUTDOWN  = 1'b1;
  localparam logic       RST_TEST      = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // waiting for CS to fall
    ST_SHIFT    = 2'd1,  // CS low, collecting bits
    ST_DISARMED = 2'd2   // CS was low when reset released; wait for CS high
  } rx_state_t;

endpackage

// File: rtl/max7219_receiver_spi_sync_edge.sv
// spi_sync_edge
//   Multi-flop synchronizer for one asynchronous pin followed by a one-flop
//   edge detector.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   async_in  : raw pin
//   level     : synchronized pin level
//   rise/fall : single-cycle pulses on synchronized level transitions
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/max7219_receiver.sv
// max7219_receiver
//   Clocked model of the MAX7219 serial input. Samples CS/SCLK/DIN in the clk
//   domain, assembles 16-bit frames and decodes them into the register set.
// Ports:
//   clk, rst                 : system clock, asynchronous active-high reset
//   cs_in, sclk_in, din_in   : asynchronous SPI pins (CS active-low)
//   row_sel / row_data       : combinational read of the 8 digit rows
//   decode_mode, intensity,
//   scan_limit, shutdown,
//   display_test             : decoded control registers
//   frame_valid/frame_error  : one-cycle pulses for accepted / short frames
//   frame_addr/frame_data    : contents of the last accepted frame
//   dout_out                 : daisy-chain output (shift bit 15 on SCLK fall)
module max7219_receiver
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_in,
  input  logic       sclk_in,
  input  logic       din_in,
  input  logic [2:0] row_sel,
  output logic [7:0] row_data,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown,
  output logic       display_test,
  output logic       frame_valid,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_error,
  output logic       dout_out
);

  localparam int PIN_CS   = 0;
  localparam int PIN_SCLK = 1;
  localparam int PIN_DIN  = 2;

  logic [2:0] pin_bus;
  logic [2:0] pin_level;
  logic [2:0] pin_rise;
  logic [2:0] pin_fall;

  assign pin_bus = {din_in, sclk_in, cs_in};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (pin_bus[gi]),
        .level    (pin_level[gi]),
        .rise     (pin_rise[gi]),
        .fall     (pin_fall[gi])
      );
    end
  endgenerate

  logic cs_level, cs_rise, cs_fall, sclk_rise, sclk_fall, din_level;
  assign cs_level  = pin_level[PIN_CS];
  assign cs_rise   = pin_rise[PIN_CS];
  assign cs_fall   = pin_fall[PIN_CS];
  assign sclk_rise = pin_rise[PIN_SCLK];
  assign sclk_fall = pin_fall[PIN_SCLK];
  assign din_level = pin_level[PIN_DIN];

  // Synchronizer outputs this block has no use for.
  logic unused_edges;
  assign unused_edges = ^{pin_level[PIN_SCLK], pin_rise[PIN_DIN], pin_fall[PIN_DIN]};

  rx_state_t   state_reg, state_next;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt_reg;
  logic [7:0]  rows_reg [NUM_ROWS];

  logic do_shift, do_dout, clr_cnt, do_frame, do_error;

  // Next-state and control decode
  always_comb begin
    state_next = state_reg;
    do_shift   = 1'b0;
    do_dout    = 1'b0;
    clr_cnt    = 1'b0;
    do_frame   = 1'b0;
    do_error   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next = ST_SHIFT;
          clr_cnt    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          // CS rising takes priority; any SCLK edge in the same cycle is dropped.
          state_next = ST_IDLE;
          if (bit_cnt_reg >= 5'(FRAME_BITS)) begin
            do_frame = 1'b1;
          end else begin
            do_error = 1'b1;
          end
        end else begin
          do_shift = sclk_rise;
          do_dout  = sclk_fall;
        end
      end
      ST_DISARMED: begin
        // Level-sensitive so the CS rise hidden by the synchronizer reset
        // still re-arms the receiver without flagging an error.
        if (cs_level) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_DISARMED;
    endcase
  end

  // The synchronizers reset to 0, so synchronized CS always reads low at
  // reset release; starting in DISARMED is therefore the correct entry state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_DISARMED;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      dout_out     <= 1'b0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      frame_addr   <= '0;
      frame_data   <= '0;
      decode_mode  <= RST_DECODE;
      intensity    <= RST_INTENSITY;
      scan_limit   <= RST_SCANLIMIT;
      shutdown     <= RST_SHUTDOWN;
      display_test <= RST_TEST;
      for (int i = 0; i < NUM_ROWS; i++) begin
        rows_reg[i] <= RST_ROW;
      end
    end else begin
      state_reg   <= state_next;
      frame_valid <= do_frame;
      frame_error <= do_error;

      if (clr_cnt) begin
        bit_cnt_reg <= '0;
      end else if (do_shift && bit_cnt_reg != 5'(FRAME_BITS)) begin
        bit_cnt_reg <= bit_cnt_reg + 5'd1;
      end

      if (do_shift) begin
        shift_reg <= {shift_reg[14:0], din_level};
      end

      if (do_dout) begin
        dout_out <= shift_reg[15];
      end

      if (do_frame) begin
        frame_addr <= shift_reg[11:8];
        frame_data <= shift_reg[7:0];
        case (shift_reg[11:8])
          ADDR_DECODE:    decode_mode  <= shift_reg[7:0];
          ADDR_INTENSITY: intensity    <= shift_reg[3:0];
          ADDR_SCANLIMIT: scan_limit   <= shift_reg[2:0];
          ADDR_SHUTDOWN:  shutdown     <= ~shift_reg[0];
          ADDR_TEST:      display_test <= shift_reg[0];
          default: ;  // no-op, digits (below) and 0xD/0xE
        endcase
        for (int i = 0; i < NUM_ROWS; i++) begin
          if (shift_reg[11:8] == 4'(ADDR_DIGIT0 + i)) begin
            rows_reg[i] <= shift_reg[7:0];
          end
        end
      end
    end
  end

  assign row_data = rows_reg[row_sel];

endmodule
